fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Fetch-stage sequencer. Owns the fetch PC register and issues instruction-memory requests over a valid/ready request channel with a fixed-order response.
- Buffers returned instructions in a 2-entry queue toward decode.
- Handles branch/jump redirects from execute (PCSrcE/PCTargetE), including squashing a response already in flight.
- Exports stall_f_o to the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- QDEPTH, 2, instruction queue depth. Fixed at 2; other values are unsupported.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- redirect_i  in  1  PCSrcE; control-flow redirect this cycle.
- redirect_pc_i  in  32  PCTargetE; redirect target.
- stall_d_i  in  1  decode cannot accept an instruction.
- imem_req_valid_o  out  1  request valid.
- imem_req_addr_o  out  32  request address (= pc_o).
- imem_req_ready_i  in  1  memory accepts request.
- imem_resp_valid_i  in  1  response valid. No backpressure; at most one per outstanding request, in order.
- imem_resp_data_i  in  32  instruction word.
- pc_o  out  32  current fetch PC (PCF).
- instr_valid_o  out  1  queue head valid.
- instr_o  out  32  queue head instruction.
- instr_pc_o  out  32  PC of queue head.
- stall_f_o  out  1  fetch PC not advancing this cycle.

Behaviour:
- Reset (rst=0 at edge):
  - pc=RESET_PC, state=REQ, queue count=0, all queue entries 0.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - imem_req_valid_o forced 0 while rst=0.
  - Reset mid-operation abandons any in-flight request. imem is reset by the same rst, so no stale response arrives.
- States: REQ (no request outstanding), WAIT (one outstanding, response kept), DROP (one outstanding, response to be discarded).
- Outstanding requests: max 1.
- imem_req_valid_o = rst && state==REQ && count<2 && !redirect_i. Redirect cycles never issue, so a stale address is never sent.
- Handshake: req_valid && req_ready at edge.
  - Result: state<=WAIT, inflight_pc<=pc, pc<=pc+4.
  - Addition is mod 2^32; 32'hFFFF_FFFC wraps to 0.
- stall_f_o = !(imem_req_valid_o && imem_req_ready_i). Purely combinational.
- Consume: instr_valid_o && !stall_d_i at edge pops the head.
- WAIT + resp_valid (no redirect): push {resp_data, inflight_pc}; state<=REQ.
  - Push and pop in the same cycle keep count unchanged; order is preserved.
  - count<2 is guaranteed by the issue rule.
- Redirect at edge, in every state:
  - pc<=redirect_pc_i; queue flushed (count<=0; a same-cycle consume/push is ignored).
  - REQ -> REQ.
  - WAIT without resp_valid -> DROP.
  - WAIT with resp_valid -> REQ, response discarded.
  - DROP without resp -> DROP.
  - DROP with resp -> REQ.
- DROP + resp_valid (no redirect): discard data, state<=REQ. pc unchanged and already holds the redirect target.
- resp_valid in REQ: ignored (protocol error, no state change).
- Head outputs are driven from registered queue storage. No combinational path from imem_resp_* to instr_*.
- Latency: request handshake at edge N, response at edge N+k (k≥1) → instr_valid_o high after edge N+k.
- Throughput: max one instruction per 2 cycles with single-cycle memory.

Test Plan:
- Reset release with req_ready=1 and 1-cycle resp: requests 0x0, 0x4, 0x8 in that order. instr_pc_o sequence 0x0, 0x4, 0x8. stall_f_o=0 on each handshake cycle.
- stall_d_i=1 held for 10 cycles: queue fills to 2 (PCs 0x0, 0x4). imem_req_valid_o=0, stall_f_o=1 and pc_o=0x8 held. Releasing the stall drains 0x0 then 0x4, then the 0x8 request issues.
- Redirect to 0x100 while a response for 0x8 is outstanding: state DROP. The next response is discarded, instr_valid_o=0. Next request address is 0x100 and the next instr_pc_o is 0x100.
- Redirect to 0x200 in the same cycle as a WAIT response: the response is dropped, the queue is flushed, and imem_req_valid_o=1 with addr 0x200 on the next cycle.
- pc=32'hFFFF_FFFC handshake → pc_o=0x0 next cycle. Separately, rst=0 asserted in WAIT with count=1 → count=0, pc=RESET_PC, imem_req_valid_o=0 until rst=1.
- req_ready=0 for 5 cycles: addr stable at the same pc, stall_f_o=1 throughout. A redirect during this window changes the address the cycle after the redirect.

Source files
------------

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the fetch PC, issues one outstanding imem request at a time,
// buffers responses in a 2-entry queue toward decode and squashes responses across redirects.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_d_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        stall_f_o,
  output logic [1:0]  fsm_state
);

  // Request channel: a request transfers on a rising edge where imem_req_valid_o and
  // imem_req_ready_i are both high; once raised, valid stays up with a stable address
  // until it transfers unless a redirect intervenes. Responses have no backpressure and
  // return in order, at most one per transferred request.

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [1:0] FULL = 2'(QDEPTH);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic [1:0]  count;
  logic [31:0] q_data [QDEPTH];
  logic [31:0] q_pc   [QDEPTH];

  logic handshake;
  logic pop;
  logic push;

  // Redirect cycles never issue, so a stale address never reaches memory.
  assign imem_req_valid_o = rst && (state == REQ) && (count < FULL) && !redirect_i;
  assign imem_req_addr_o  = pc;
  assign handshake        = imem_req_valid_o && imem_req_ready_i;
  assign stall_f_o        = !handshake;
  assign pc_o             = pc;

  assign instr_valid_o = (count != 2'd0);
  assign instr_o       = q_data[0];
  assign instr_pc_o    = q_pc[0];
  assign fsm_state     = state;

  assign pop  = instr_valid_o && !stall_d_i;
  assign push = (state == WAIT) && imem_resp_valid_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      inflight_pc <= '0;
      count       <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect_i) begin
      // Flush wins over any same-cycle push/pop; an outstanding response must be discarded.
      pc    <= redirect_pc_i;
      count <= '0;
      case (state)
        WAIT:    state <= imem_resp_valid_i ? REQ : DROP;
        DROP:    state <= imem_resp_valid_i ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (handshake) begin
            state       <= WAIT;
            inflight_pc <= pc;
            pc          <= pc + 32'd4;
          end
        end
        WAIT: if (imem_resp_valid_i) state <= REQ;
        DROP: if (imem_resp_valid_i) state <= REQ;
        default: state <= REQ;
      endcase

      // Head always lives in slot 0; a pop shifts slot 1 down.
      if (pop && push) begin
        if (count == 2'd1) begin
          q_data[0] <= imem_resp_data_i;
          q_pc[0]   <= inflight_pc;
        end else begin
          q_data[0] <= q_data[1];
          q_pc[0]   <= q_pc[1];
          q_data[1] <= imem_resp_data_i;
          q_pc[1]   <= inflight_pc;
        end
      end else if (pop) begin
        q_data[0] <= q_data[1];
        q_pc[0]   <= q_pc[1];
        count     <= count - 2'd1;
      end else if (push) begin
        q_data[count[0]] <= imem_resp_data_i;
        q_pc[count[0]]   <= inflight_pc;
        count            <= count + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then randomized traffic, all checked against
// a queue-based reference model and an imem model with random response latency.
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_d_i = 1'b0;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i = 1'b0;
  logic        imem_resp_valid_i = 1'b0;
  logic [31:0] imem_resp_data_i = '0;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        stall_f_o;
  logic [1:0]  fsm_state;

  fetch_controller #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .stall_d_i         (stall_d_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .pc_o              (pc_o),
    .instr_valid_o     (instr_valid_o),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .stall_f_o         (stall_f_o),
    .fsm_state         (fsm_state)
  );

  // reference model: fetch PC, one outstanding request, queue of {pc, instr} toward decode
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_inflight = '0;
  bit          m_out = 1'b0;
  bit          m_drop = 1'b0;
  int          m_cd = 0;
  int          lat_max = 0;
  logic [63:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model
  // across the coming rising edge.
  task automatic step(input bit r, input bit sd, input bit rdy, input bit rd,
                      input logic [31:0] tgt, input bit hold);
    bit exp_rv;
    bit resp;
    @(negedge clk);
    rst              = r;
    stall_d_i        = sd;
    imem_req_ready_i = rdy;
    redirect_i       = rd;
    redirect_pc_i    = tgt;
    resp             = r && m_out && (m_cd == 0) && !hold;
    imem_resp_valid_i = resp;
    imem_resp_data_i  = resp ? mem_word(m_inflight) : $urandom();
    #1;
    exp_rv = r && !m_out && (exp_q.size() < 2) && !rd;
    check("pc", pc_o, m_pc);
    check("req_valid", 32'(imem_req_valid_o), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr_o, m_pc);
    check("stall_f", 32'(stall_f_o), 32'(!(exp_rv && rdy)));
    check("instr_valid", 32'(instr_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("instr_pc", instr_pc_o, exp_q[0][63:32]);
      check("instr", instr_o, exp_q[0][31:0]);
    end

    if (!r) begin
      m_pc = RESET_PC; m_out = 0; m_drop = 0; m_cd = 0;
      exp_q.delete();
    end else begin
      if (m_out && m_cd > 0) m_cd--;
      if (rd) begin
        m_pc = tgt;
        exp_q.delete();
        if (m_out && resp) begin
          m_out = 0; m_drop = 0;
        end else if (m_out) begin
          m_drop = 1;
        end
      end else begin
        if (exp_q.size() != 0 && !sd) void'(exp_q.pop_front());
        if (resp) begin
          if (!m_drop) exp_q.push_back({m_inflight, mem_word(m_inflight)});
          m_out = 0; m_drop = 0;
        end
        if (exp_rv && rdy) begin
          m_out = 1; m_drop = 0;
          m_inflight = m_pc;
          m_pc = m_pc + 32'd4;
          m_cd = $urandom_range(0, lat_max);
        end
      end
    end
  endtask

  logic [31:0] req_seen[$];
  logic [31:0] ipc_seen[$];
  bit          found;
  logic [31:0] tgt;

  initial begin
    lat_max = 0;
    repeat (3) step(0, 0, 1, 0, 32'h0, 0);
    check("reset_instr_valid", 32'(instr_valid_o), 32'h0);
    check("reset_instr", instr_o, 32'h0);
    check("reset_instr_pc", instr_pc_o, 32'h0);

    // in-order fetch after reset with single-cycle memory
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 0, 32'h0, 0);
      if (imem_req_valid_o && imem_req_ready_i) req_seen.push_back(imem_req_addr_o);
      if (instr_valid_o) ipc_seen.push_back(instr_pc_o);
    end
    check("t1_req0", req_seen[0], 32'h0);
    check("t1_req1", req_seen[1], 32'h4);
    check("t1_req2", req_seen[2], 32'h8);
    check("t1_ipc0", ipc_seen[0], 32'h0);
    check("t1_ipc1", ipc_seen[1], 32'h4);
    check("t1_ipc2", ipc_seen[2], 32'h8);

    // decode stall fills the queue and freezes fetch
    repeat (2) step(0, 0, 1, 0, 32'h0, 0);
    repeat (10) step(1, 1, 1, 0, 32'h0, 0);
    check("t2_pc_held", pc_o, 32'h8);
    check("t2_req_valid", 32'(imem_req_valid_o), 32'h0);
    check("t2_stall_f", 32'(stall_f_o), 32'h1);
    check("t2_head", instr_pc_o, 32'h0);
    step(1, 0, 1, 0, 32'h0, 0);
    check("t2_drain0", instr_pc_o, 32'h0);
    step(1, 0, 1, 0, 32'h0, 1);
    check("t2_drain1", instr_pc_o, 32'h4);
    check("t2_req8", imem_req_addr_o, 32'h8);
    check("t2_req8_valid", 32'(imem_req_valid_o), 32'h1);

    // redirect while the 0x8 response is outstanding: it must be squashed
    step(1, 0, 1, 1, 32'h100, 1);
    step(1, 0, 1, 0, 32'h0, 0);
    check("t3_squash_valid", 32'(instr_valid_o), 32'h0);
    check("t3_drop_noreq", 32'(imem_req_valid_o), 32'h0);
    step(1, 0, 1, 0, 32'h0, 0);
    check("t3_req_valid", 32'(imem_req_valid_o), 32'h1);
    check("t3_req_addr", imem_req_addr_o, 32'h100);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(1, 0, 1, 0, 32'h0, 0);
      if (instr_valid_o) begin
        found = 1;
        check("t3_ipc", instr_pc_o, 32'h100);
      end
    end
    check("t3_found", 32'(found), 32'h1);

    // redirect coinciding with a WAIT response
    for (int i = 0; i < 6 && !m_out; i++) step(1, 0, 1, 0, 32'h0, 1);
    check("t4_outstanding", 32'(m_out && !m_drop), 32'h1);
    step(1, 0, 1, 1, 32'h200, 0);
    step(1, 0, 1, 0, 32'h0, 0);
    check("t4_req_valid", 32'(imem_req_valid_o), 32'h1);
    check("t4_req_addr", imem_req_addr_o, 32'h200);
    check("t4_flushed", 32'(instr_valid_o), 32'h0);

    // PC wrap at the top of the address space, then reset in WAIT with one queued entry
    step(1, 1, 1, 1, 32'hffff_fffc, 0);
    step(1, 1, 1, 0, 32'h0, 0);
    check("t5_req_top", imem_req_addr_o, 32'hffff_fffc);
    step(1, 1, 1, 0, 32'h0, 0);
    check("t5_wrap", pc_o, 32'h0);
    step(1, 1, 1, 0, 32'h0, 1);
    check("t5_count1", 32'(instr_valid_o), 32'h1);
    step(0, 1, 1, 0, 32'h0, 1);
    check("t5_rst_noreq0", 32'(imem_req_valid_o), 32'h0);
    step(0, 1, 1, 0, 32'h0, 1);
    check("t5_rst_noreq1", 32'(imem_req_valid_o), 32'h0);
    check("t5_rst_pc", pc_o, RESET_PC);
    check("t5_rst_empty", 32'(instr_valid_o), 32'h0);

    // memory not ready: address held, redirect moves it the following cycle
    step(1, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0, 0);
    check("t6_addr_hold", imem_req_addr_o, RESET_PC);
    check("t6_stall", 32'(stall_f_o), 32'h1);
    step(1, 0, 0, 1, 32'h300, 0);
    check("t6_redir_noreq", 32'(imem_req_valid_o), 32'h0);
    step(1, 0, 0, 0, 32'h0, 0);
    check("t6_addr_new", imem_req_addr_o, 32'h300);
    step(1, 0, 0, 0, 32'h0, 0);
    check("t6_stall_end", 32'(stall_f_o), 32'h1);

    // randomized traffic
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      tgt = $urandom() & 32'hffff_fffc;
      if ($urandom_range(0, 3) == 0) tgt = 32'hffff_fff0 + 32'($urandom_range(0, 3) * 4);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0), tgt, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
